// File: rtl/beam_energy_scanner.sv
// beam_energy_scanner: steers two ring buffers across candidate delays,
// accumulates delay-and-sum energy per delay and reports the strongest one.
module beam_energy_scanner #(
    parameter int READBIT     = 24,
    parameter int L           = 32,
    parameter int DELTA_START = 74,
    parameter int DELTA_LAST  = 127,
    parameter int SETTLE      = 2,
    parameter int ACC_W       = 56
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_initial_finish,
    input  logic                          i_color_finish,
    input  logic [READBIT-1:0]            i_data_a,
    input  logic [READBIT-1:0]            i_data_b,
    output logic [$clog2(DELTA_LAST)-1:0] o_delta_a,
    output logic [$clog2(DELTA_LAST)-1:0] o_delta_b,
    output logic                          o_change_pointer,
    output logic                          o_black_finish,
    output logic [$clog2(DELTA_LAST)-1:0] o_best_delta,
    output logic [ACC_W-1:0]              o_best_energy,
    output logic                          o_valid
);

    localparam int DW   = $clog2(DELTA_LAST);
    localparam int ND   = DELTA_LAST - DELTA_START + 1;
    localparam int IW   = $clog2(ND);
    localparam int KW   = $clog2(L);
    localparam int CW   = $clog2(SETTLE) + 1;
    localparam int SUMW = READBIT + 1;
    localparam int SQW  = 2 * SUMW;

    localparam logic [DW-1:0] DS     = DW'(DELTA_START);
    localparam logic [DW-1:0] DL     = DW'(DELTA_LAST);
    localparam logic [DW-1:0] DSUM   = DW'(DELTA_START + DELTA_LAST);
    localparam logic [KW-1:0] K_LAST = KW'(L - 1);
    localparam logic [CW-1:0] C_LAST = CW'(SETTLE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(ND - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_SET,
        S_STEP,
        S_FLUSH,
        S_ARGMAX,
        S_DONE,
        S_WAIT_COLOR
    } state_t;

    state_t state_q, state_d;
    logic [DW-1:0] d_q, d_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cap;
    logic          clr;

    logic                   pv_q;
    logic signed [SUMW-1:0] sum_q;
    logic [IW-1:0]          idx_q;
    logic signed [SQW-1:0]  sx;
    logic signed [SQW-1:0]  sq_s;
    logic [ACC_W-1:0]       sq_ext;
    logic [ACC_W-1:0]       energy_q [ND];

    logic [IW-1:0]    scan_q;
    logic [ACC_W-1:0] run_e_q;
    logic [IW-1:0]    run_i_q;
    logic [ACC_W-1:0] win_e;
    logic [IW-1:0]    win_i;
    logic [DW-1:0]    best_d_q;
    logic [ACC_W-1:0] best_e_q;

    assign o_delta_a     = d_q;
    assign o_delta_b     = DSUM - d_q;
    assign o_best_delta  = best_d_q;
    assign o_best_energy = best_e_q;

    // Control state, steering delay, iterate index and settle counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            d_q     <= DS;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and handshake pulses toward buffers and display.
    always_comb begin
        state_d          = state_q;
        d_d              = d_q;
        k_d              = k_q;
        cnt_d            = cnt_q;
        cap              = 1'b0;
        clr              = 1'b0;
        o_change_pointer = 1'b0;
        o_black_finish   = 1'b0;
        o_valid          = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_WAIT_INIT;
            S_WAIT_INIT: begin
                clr   = 1'b1;
                k_d   = '0;
                d_d   = DS;
                cnt_d = '0;
                if (i_initial_finish) state_d = S_SET;
            end
            S_SET: begin
                if (cnt_q == C_LAST) begin
                    cnt_d = '0;
                    cap   = 1'b1;
                    if (d_q == DL) state_d = S_STEP;
                    else d_d = d_q + DW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STEP: begin
                if (k_q != K_LAST) begin
                    o_change_pointer = 1'b1;
                    k_d              = k_q + KW'(1);
                    d_d              = DS;
                    state_d          = S_SET;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_ARGMAX;
            S_ARGMAX: if (scan_q == I_LAST) state_d = S_DONE;
            S_DONE: begin
                o_black_finish = 1'b1;
                o_valid        = 1'b1;
                state_d        = S_WAIT_COLOR;
            end
            S_WAIT_COLOR: if (i_color_finish) state_d = S_WAIT_INIT;
            default: state_d = S_IDLE;
        endcase
    end

    // Sign-extended square of the captured delay-and-sum sample.
    always_comb begin
        sx     = SQW'(sum_q);
        sq_s   = sx * sx;
        sq_ext = {{(ACC_W - SQW){1'b0}}, sq_s};
    end

    // Capture stage: delay-and-sum sample tagged with its energy slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pv_q  <= 1'b0;
            sum_q <= '0;
            idx_q <= '0;
        end else begin
            pv_q <= cap;
            if (cap) begin
                sum_q <= {i_data_a[READBIT-1], i_data_a}
                       + {i_data_b[READBIT-1], i_data_b};
                idx_q <= IW'(d_q - DS);
            end
        end
    end

    // Energy bins: cleared per frame, squared sample added one cycle later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < ND; i++) energy_q[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < ND; i++) energy_q[i] <= '0;
        end else if (pv_q) begin
            energy_q[idx_q] <= energy_q[idx_q] + sq_ext;
        end
    end

    // Strict-greater compare so ties keep the lowest delay.
    always_comb begin
        win_e = run_e_q;
        win_i = run_i_q;
        if (energy_q[scan_q] > run_e_q) begin
            win_e = energy_q[scan_q];
            win_i = scan_q;
        end
    end

    // Argmax scan, one bin per cycle; result latched on the last bin.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scan_q   <= '0;
            run_e_q  <= '0;
            run_i_q  <= '0;
            best_d_q <= DS;
            best_e_q <= '0;
        end else if (state_q == S_FLUSH) begin
            scan_q  <= '0;
            run_e_q <= '0;
            run_i_q <= '0;
        end else if (state_q == S_ARGMAX) begin
            scan_q  <= scan_q + IW'(1);
            run_e_q <= win_e;
            run_i_q <= win_i;
            if (scan_q == I_LAST) begin
                best_d_q <= DS + DW'(win_i);
                best_e_q <= win_e;
            end
        end
    end

endmodule

// File: tb/tb_beam_energy_scanner.sv
// Directed bench for beam_energy_scanner with a mock ring-buffer pair
// and a queue of expected frame results.
module tb_beam_energy_scanner;

    localparam int RB  = 24;
    localparam int ACC = 56;
    localparam int DW  = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            init_f;
    logic            color_f;
    logic [RB-1:0]   da;
    logic [RB-1:0]   db;
    logic [DW-1:0]   delta_a;
    logic [DW-1:0]   delta_b;
    logic            cp;
    logic            bf;
    logic [DW-1:0]   best_d;
    logic [ACC-1:0]  best_e;
    logic            valid;

    beam_energy_scanner dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_initial_finish (init_f),
        .i_color_finish   (color_f),
        .i_data_a         (da),
        .i_data_b         (db),
        .o_delta_a        (delta_a),
        .o_delta_b        (delta_b),
        .o_change_pointer (cp),
        .o_black_finish   (bf),
        .o_best_delta     (best_d),
        .o_best_energy    (best_e),
        .o_valid          (valid)
    );

    always #10 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [ACC-1:0] e;
    } exp_t;
    exp_t sb[$];

    // Mock buffers: output follows the steering delay with one register,
    // so data reflects a delay two cycles after the scanner computes it.
    int            mode = 0;
    logic [DW-1:0] a_d1;
    always @(posedge clk) a_d1 <= delta_a;

    always_comb begin
        case (mode)
            0: begin
                da = 24'd100;
                db = 24'd100;
            end
            1: begin
                da = (a_d1 == 7'd90) ? 24'd1000 : 24'd0;
                db = 24'd0;
            end
            default: begin
                da = 24'h800000;
                db = 24'h800000;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    int            cp_cnt = 0;
    int            bf_cnt = 0;
    int            v_cnt  = 0;
    int            run    = 0;
    logic          hold_en = 1'b0;
    logic [DW-1:0] prev_a = '0;

    always @(negedge clk) begin
        if (cp) cp_cnt++;
        if (bf) bf_cnt++;
        if (valid) v_cnt++;
        chk("delta_b_mirror", 64'(delta_b), 64'(201 - int'(delta_a)));
        if (delta_a !== prev_a) begin
            if (hold_en) chk("delta_hold", 64'(run >= 2), 64'd1);
            run    = 1;
            prev_a = delta_a;
        end else begin
            run++;
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_delta_a"}, 64'(delta_a), 64'd74);
        chk({tag, "_delta_b"}, 64'(delta_b), 64'd127);
        chk({tag, "_cp"}, 64'(cp), 64'd0);
        chk({tag, "_bf"}, 64'(bf), 64'd0);
        chk({tag, "_valid"}, 64'(valid), 64'd0);
        chk({tag, "_best_d"}, 64'(best_d), 64'd74);
        chk({tag, "_best_e"}, 64'(best_e), 64'd0);
    endtask

    task automatic start_frame(input int m, input logic [DW-1:0] ed,
                               input logic [ACC-1:0] ee);
        exp_t x;
        x.d    = ed;
        x.e    = ee;
        mode   = m;
        cp_cnt = 0;
        bf_cnt = 0;
        v_cnt  = 0;
        sb.push_back(x);
        @(posedge clk);
        #1 init_f = 1'b1;
        @(posedge clk);
        #1 init_f = 1'b0;
    endtask

    task automatic finish_frame(input string tag);
        bit   got;
        exp_t x;
        got = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_valid_seen"}, 64'(got), 64'd1);
        if (got && sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, "_best_delta"}, 64'(best_d), 64'(x.d));
            chk({tag, "_best_energy"}, 64'(best_e), 64'(x.e));
            chk({tag, "_bf_with_valid"}, 64'(bf), 64'd1);
        end
        repeat (3) @(negedge clk);
        chk({tag, "_cp_pulses"}, 64'(cp_cnt), 64'd31);
        chk({tag, "_bf_pulses"}, 64'(bf_cnt), 64'd1);
        chk({tag, "_valid_pulses"}, 64'(v_cnt), 64'd1);
    endtask

    task automatic color_pulse();
        @(posedge clk);
        #1 color_f = 1'b1;
        @(posedge clk);
        #1 color_f = 1'b0;
    endtask

    initial begin
        int c;
        rst     = 1'b1;
        init_f  = 1'b0;
        color_f = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // Frame 1: constant input, all bins tie; stray color_finish mid-scan.
        start_frame(0, 7'd74, 56'd1280000);
        hold_en = 1'b1;
        repeat (100) @(posedge clk);
        #1 color_f = 1'b1;
        @(posedge clk);
        #1 color_f = 1'b0;
        finish_frame("f1_const");
        hold_en = 1'b0;

        // initial_finish held high while waiting for display: must idle.
        cp_cnt = 0;
        v_cnt  = 0;
        init_f = 1'b1;
        repeat (200) @(posedge clk);
        #1 init_f = 1'b0;
        @(negedge clk);
        chk("wait_color_cp", 64'(cp_cnt), 64'd0);
        chk("wait_color_valid", 64'(v_cnt), 64'd0);
        chk("wait_color_delta", 64'(delta_a), 64'd127);
        color_pulse();

        // Frame 2: single hot delay.
        start_frame(1, 7'd90, 56'd32000000);
        finish_frame("f2_hot90");
        color_pulse();

        // Frame 3: full-scale negative samples, maximum energy.
        start_frame(2, 7'd74, 56'd9007199254740992);
        finish_frame("f3_fullscale");
        color_pulse();

        // Frame 4: aborted by reset at k=10.
        start_frame(0, 7'd74, 56'd1280000);
        c = 0;
        for (int g = 0; g < 5000 && c < 10; g++) begin
            @(negedge clk);
            if (cp === 1'b1) c++;
        end
        chk("abort_reach_k10", 64'(c), 64'd10);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset("abort");
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("abort_no_bf", 64'(bf_cnt), 64'd0);
        chk("abort_no_valid", 64'(v_cnt), 64'd0);

        // Frame 5: fresh frame after abort.
        repeat (2) @(posedge clk);
        start_frame(1, 7'd90, 56'd32000000);
        hold_en = 1'b1;
        finish_frame("f5_after_abort");
        hold_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
